// File: rtl/alu_seq_pkg.sv
// Shared constants for the sequential ALU: default datapath width and func codes.
package alu_seq_pkg;

    localparam int DEF_WIDTH = 32;

    localparam logic [5:0] F_ADD  = 6'd0;
    localparam logic [5:0] F_SUB  = 6'd1;
    localparam logic [5:0] F_OR   = 6'd2;
    localparam logic [5:0] F_NEG  = 6'd3;
    localparam logic [5:0] F_AND  = 6'd4;
    localparam logic [5:0] F_XOR  = 6'd5;
    localparam logic [5:0] F_SLL  = 6'd6;
    localparam logic [5:0] F_SRL  = 6'd7;
    localparam logic [5:0] F_SLLV = 6'd8;
    localparam logic [5:0] F_SRLV = 6'd9;
    localparam logic [5:0] F_SRA  = 6'd10;
    localparam logic [5:0] F_SRAV = 6'd11;
    localparam logic [5:0] F_MULU = 6'd12;
    localparam logic [5:0] F_DIVU = 6'd13;

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle.
// Busy for WIDTH cycles after i_start, then a one-cycle o_done; results hold until the next start.
module alu_seq_muldiv
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

    logic             r_busy;
    logic             r_done;
    logic             r_op;
    logic [SHW-1:0]   r_cnt;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic [WIDTH:0]   w_msum;
    logic [WIDTH:0]   w_rsh;
    logic [WIDTH-1:0] w_nhi;
    logic [WIDTH-1:0] w_nlo;

    // Multiply: hi accumulates, lo shifts out multiplier bits and in product bits.
    // Divide: {hi,lo} shifts left, hi holds the partial remainder, lo collects quotient bits.
    always_comb begin
        w_msum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
        w_rsh  = {r_hi, r_lo[WIDTH-1]};
        if (r_op) begin
            if (w_rsh >= {1'b0, r_b}) begin
                w_nhi = w_rsh[WIDTH-1:0] - r_b;
                w_nlo = {r_lo[WIDTH-2:0], 1'b1};
            end else begin
                w_nhi = w_rsh[WIDTH-1:0];
                w_nlo = {r_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            w_nhi = w_msum[WIDTH:1];
            w_nlo = {w_msum[0], r_lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_op   <= 1'b0;
            r_cnt  <= '0;
            r_b    <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_busy <= 1'b1;
                r_cnt  <= '0;
                r_op   <= i_op;
                r_b    <= i_b;
                r_hi   <= '0;
                r_lo   <= i_a;
            end else if (r_busy) begin
                r_hi  <= w_nhi;
                r_lo  <= w_nlo;
                r_cnt <= r_cnt + SHW'(1);
                if (r_cnt == LAST) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

endmodule

// File: rtl/alu_seq_unit.sv
// Sequential ALU: single-cycle logic/arith/shift ops, iterative MULU/DIVU via alu_seq_muldiv.
// Done one cycle after capture (WIDTH+1 for MULU/DIVU); start is ignored while busy.
module alu_seq_unit
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       func,
    input  logic [WIDTH-1:0] inp1,
    input  logic [WIDTH-1:0] inp2,
    input  logic [SHW-1:0]   shAmt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res1,
    output logic [WIDTH-1:0] res2,
    output logic             carryFlag,
    output logic             signFlag,
    output logic             overflowFlag,
    output logic             zeroFlag
);

    localparam int MSB = WIDTH - 1;
    localparam logic [WIDTH:0] ONE = (WIDTH + 1)'(1);

    logic             w_md_busy;
    logic             w_md_done;
    logic [WIDTH-1:0] w_md_hi;
    logic [WIDTH-1:0] w_md_lo;
    logic             w_md_ov;
    logic             w_md_zero;

    logic             w_accept;
    logic             w_is_md;
    logic [WIDTH:0]   w_wide;
    logic [WIDTH-1:0] w_sc_res1;
    logic             w_sc_carry;
    logic             w_sc_ov;

    logic             r_done;
    logic [WIDTH-1:0] r_res1;
    logic [WIDTH-1:0] r_res2;
    logic             r_carry;
    logic             r_sign;
    logic             r_ov;
    logic             r_zero;
    logic             r_md_div;
    logic             r_div0;

    assign w_accept = start & ~w_md_busy;
    assign w_is_md  = (func == F_MULU) || (func == F_DIVU);

    alu_seq_muldiv #(.WIDTH(WIDTH), .SHW(SHW)) u_muldiv (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_accept & w_is_md),
        .i_op    (func == F_DIVU),
        .i_a     (inp1),
        .i_b     (inp2),
        .o_busy  (w_md_busy),
        .o_done  (w_md_done),
        .o_hi    (w_md_hi),
        .o_lo    (w_md_lo)
    );

    always_comb begin
        w_wide     = '0;
        w_sc_res1  = '0;
        w_sc_carry = 1'b0;
        w_sc_ov    = 1'b0;
        case (func)
            F_ADD: begin
                w_wide     = {1'b0, inp1} + {1'b0, inp2};
                w_sc_res1  = w_wide[MSB:0];
                w_sc_carry = w_wide[WIDTH];
                w_sc_ov    = (inp1[MSB] == inp2[MSB]) && (w_wide[MSB] != inp1[MSB]);
            end
            F_SUB: begin
                w_wide     = {1'b0, inp1} + {1'b0, ~inp2} + ONE;
                w_sc_res1  = w_wide[MSB:0];
                w_sc_carry = w_wide[WIDTH];
                w_sc_ov    = (inp1[MSB] != inp2[MSB]) && (w_wide[MSB] != inp1[MSB]);
            end
            F_NEG: begin
                w_wide     = {1'b0, ~inp1} + ONE;
                w_sc_res1  = w_wide[MSB:0];
                w_sc_carry = w_wide[WIDTH];
                // Only the most negative value stays negative when negated.
                w_sc_ov    = inp1[MSB] & w_wide[MSB];
            end
            F_OR:   w_sc_res1 = inp1 | inp2;
            F_AND:  w_sc_res1 = inp1 & inp2;
            F_XOR:  w_sc_res1 = inp1 ^ inp2;
            F_SLL:  w_sc_res1 = inp1 << shAmt;
            F_SRL:  w_sc_res1 = inp1 >> shAmt;
            F_SLLV: w_sc_res1 = inp1 << inp2[SHW-1:0];
            F_SRLV: w_sc_res1 = inp1 >> inp2[SHW-1:0];
            F_SRA:  w_sc_res1 = $unsigned($signed(inp1) >>> shAmt);
            F_SRAV: w_sc_res1 = $unsigned($signed(inp1) >>> inp2[SHW-1:0]);
            default: ;
        endcase
    end

    assign w_md_ov   = r_md_div ? r_div0 : (w_md_hi != '0);
    assign w_md_zero = r_md_div ? (w_md_lo == '0) : ({w_md_hi, w_md_lo} == '0);

    // A single-cycle capture in the muldiv done cycle is the newer result and wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done   <= 1'b0;
            r_res1   <= '0;
            r_res2   <= '0;
            r_carry  <= 1'b0;
            r_sign   <= 1'b0;
            r_ov     <= 1'b0;
            r_zero   <= 1'b0;
            r_md_div <= 1'b0;
            r_div0   <= 1'b0;
        end else begin
            r_done <= w_accept & ~w_is_md;
            if (w_accept && !w_is_md) begin
                r_res1  <= w_sc_res1;
                r_res2  <= '0;
                r_carry <= w_sc_carry;
                r_sign  <= w_sc_res1[MSB];
                r_ov    <= w_sc_ov;
                r_zero  <= (w_sc_res1 == '0);
            end else if (w_md_done) begin
                r_res1  <= w_md_lo;
                r_res2  <= w_md_hi;
                r_carry <= 1'b0;
                r_sign  <= w_md_lo[MSB];
                r_ov    <= w_md_ov;
                r_zero  <= w_md_zero;
            end
            if (w_accept && w_is_md) begin
                r_md_div <= (func == F_DIVU);
                r_div0   <= (inp2 == '0);
            end
        end
    end

    // During the muldiv done cycle the result is shown straight from the datapath registers.
    assign busy         = w_md_busy;
    assign done         = r_done | w_md_done;
    assign res1         = w_md_done ? w_md_lo   : r_res1;
    assign res2         = w_md_done ? w_md_hi   : r_res2;
    assign carryFlag    = w_md_done ? 1'b0      : r_carry;
    assign signFlag     = w_md_done ? w_md_lo[MSB] : r_sign;
    assign overflowFlag = w_md_done ? w_md_ov   : r_ov;
    assign zeroFlag     = w_md_done ? w_md_zero : r_zero;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Self-checking bench for alu_seq_unit at WIDTH=32: vector table plus multi-cycle sequences.
module tb_alu_seq_unit;
    import alu_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  func;
    logic [31:0] inp1, inp2;
    logic [4:0]  shAmt;
    logic        busy, done;
    logic [31:0] res1, res2;
    logic        carryFlag, signFlag, overflowFlag, zeroFlag;

    typedef struct {
        string       name;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [3:0]  fl;     // {carry, sign, overflow, zero}
    } exp_t;

    typedef struct {
        string       name;
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [3:0]  fl;
    } vec_t;

    exp_t sb[$];
    vec_t vt[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    alu_seq_unit #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .func         (func),
        .inp1         (inp1),
        .inp2         (inp2),
        .shAmt        (shAmt),
        .busy         (busy),
        .done         (done),
        .res1         (res1),
        .res2         (res2),
        .carryFlag    (carryFlag),
        .signFlag     (signFlag),
        .overflowFlag (overflowFlag),
        .zeroFlag     (zeroFlag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [67:0] act, input logic [67:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got res1=%h res2=%h required no done pulse", res1, res2);
            end else begin
                mon_e = sb.pop_front();
                chk(mon_e.name, {res1, res2, carryFlag, signFlag, overflowFlag, zeroFlag},
                    {mon_e.r1, mon_e.r2, mon_e.fl});
            end
        end
    end

    task automatic addv(input string nm, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input logic [31:0] r1, input logic [31:0] r2, input logic [3:0] fl);
        vec_t v;
        v.name = nm; v.f = f; v.a = a; v.b = b; v.sh = sh; v.r1 = r1; v.r2 = r2; v.fl = fl;
        vt.push_back(v);
    endtask

    task automatic start_op(input string nm, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] sh, input logic [31:0] r1, input logic [31:0] r2, input logic [3:0] fl);
        exp_t e;
        e.name = nm; e.r1 = r1; e.r2 = r2; e.fl = fl;
        sb.push_back(e);
        func = f; inp1 = a; inp2 = b; shAmt = sh; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: got %0d results outstanding required 0", nm, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        rst = 1'b1; start = 1'b0; func = '0; inp1 = '0; inp2 = '0; shAmt = '0;
        #3;
        chk("reset_state", {busy, done, res1, res2, carryFlag, signFlag, overflowFlag, zeroFlag}, '0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        addv("add_max",   F_ADD,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0,  32'hFFFFFFFE, 0, 4'b1100);
        addv("add_zero",  F_ADD,  32'd12,       32'hFFFFFFF4, 5'd0,  32'h0,        0, 4'b1001);
        addv("add_ovf",   F_ADD,  32'h7FFFFFFF, 32'd1,        5'd0,  32'h80000000, 0, 4'b0110);
        addv("sub_neg",   F_SUB,  32'd5,        32'd7,        5'd0,  32'hFFFFFFFE, 0, 4'b0100);
        addv("sub_pos",   F_SUB,  32'd7,        32'd5,        5'd0,  32'd2,        0, 4'b1000);
        addv("sub_ovf",   F_SUB,  32'h80000000, 32'd1,        5'd0,  32'h7FFFFFFF, 0, 4'b1010);
        addv("neg_one",   F_NEG,  32'd1,        32'd9,        5'd0,  32'hFFFFFFFF, 0, 4'b0100);
        addv("neg_zero",  F_NEG,  32'd0,        32'd0,        5'd0,  32'h0,        0, 4'b1001);
        addv("neg_min",   F_NEG,  32'h80000000, 32'd0,        5'd0,  32'h80000000, 0, 4'b0110);
        addv("or",        F_OR,   32'hF0F0F0F0, 32'h0F0F0F0F, 5'd0,  32'hFFFFFFFF, 0, 4'b0100);
        addv("and",       F_AND,  32'hF0F0F0F0, 32'h0FF00FF0, 5'd0,  32'h00F000F0, 0, 4'b0000);
        addv("xor",       F_XOR,  32'hAAAAAAAA, 32'hAAAAAAAA, 5'd0,  32'h0,        0, 4'b0001);
        addv("sll_31",    F_SLL,  32'd1,        32'h0000FFFF, 5'd31, 32'h80000000, 0, 4'b0100);
        addv("srl_31",    F_SRL,  32'h80000000, 32'd7,        5'd31, 32'd1,        0, 4'b0000);
        addv("sllv_mask", F_SLLV, 32'd3,        32'h00000024, 5'd1,  32'h30,       0, 4'b0000);
        addv("srlv_5",    F_SRLV, 32'hFFFFFFFF, 32'd5,        5'd0,  32'h07FFFFFF, 0, 4'b0000);
        addv("sra_neg",   F_SRA,  32'h80000000, 32'd0,        5'd4,  32'hF8000000, 0, 4'b0100);
        addv("sra_pos",   F_SRA,  32'h40000000, 32'd0,        5'd4,  32'h04000000, 0, 4'b0000);
        addv("srav_31",   F_SRAV, 32'h80000000, 32'h0000003F, 5'd0,  32'hFFFFFFFF, 0, 4'b0100);
        addv("illegal14", 6'd14,  32'hFFFFFFFF, 32'd1,        5'd3,  32'h0,        0, 4'b0001);
        addv("illegal63", 6'd63,  32'h12345678, 32'hFFFFFFFF, 5'd7,  32'h0,        0, 4'b0001);

        for (int i = 0; i < vt.size(); i++) begin
            start_op(vt[i].name, vt[i].f, vt[i].a, vt[i].b, vt[i].sh, vt[i].r1, vt[i].r2, vt[i].fl);
            wait_idle(vt[i].name);
        end

        // MULU with a start attempt while busy, then a DIVU issued in the done cycle.
        start_op("mulu_max_x2", F_MULU, 32'hFFFFFFFF, 32'd2, 5'd0, 32'hFFFFFFFE, 32'd1, 4'b0110);
        cnt = 0;
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk);
            if (k <= 32 && busy) cnt++;
            if (k == 5) begin
                func = F_ADD; inp1 = 32'd1; inp2 = 32'd1; start = 1'b1;
            end
            if (k == 6) start = 1'b0;
            if (k == 33) begin
                chk("mulu_busy_cycles", 68'(cnt), 68'd32);
                chk("mulu_done_cycle", {66'd0, done, busy}, {66'd0, 2'b10});
                start_op("divu_100_7_b2b", F_DIVU, 32'd100, 32'd7, 5'd0, 32'd14, 32'd2, 4'b0000);
            end
        end
        wait_idle("divu_100_7_b2b");

        start_op("divu_by_zero", F_DIVU, 32'd100, 32'd0, 5'd0, 32'hFFFFFFFF, 32'd100, 4'b0110);
        wait_idle("divu_by_zero");
        repeat (3) @(negedge clk);
        chk("divu_hold", {res1, res2, carryFlag, signFlag, overflowFlag, zeroFlag},
            {32'hFFFFFFFF, 32'd100, 4'b0110});

        // Reset in the middle of a DIVU: outputs clear at once and no done follows.
        func = F_DIVU; inp1 = 32'd1000; inp2 = 32'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        chk("divu_busy_before_rst", {67'd0, busy}, {67'd0, 1'b1});
        #1 rst = 1'b1;
        #1;
        chk("rst_abort_outputs", {busy, done, res1, res2, carryFlag, signFlag, overflowFlag, zeroFlag}, '0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("rst_no_busy", {67'd0, busy}, 68'd0);

        start_op("add_3_4_after_rst", F_ADD, 32'd3, 32'd4, 5'd0, 32'd7, 32'd0, 4'b0000);
        wait_idle("add_3_4_after_rst");
        start_op("mulu_hi_only", F_MULU, 32'h00010000, 32'h00010000, 5'd0, 32'h0, 32'd1, 4'b0010);
        wait_idle("mulu_hi_only");
        start_op("mulu_zero", F_MULU, 32'd0, 32'd5, 5'd0, 32'h0, 32'h0, 4'b0001);
        wait_idle("mulu_zero");
        start_op("divu_small", F_DIVU, 32'd5, 32'd9, 5'd0, 32'h0, 32'd5, 4'b0001);
        wait_idle("divu_small");
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_seq_unit.md
ALU_SEQ_UNIT -- requirements
Module: alu_seq_unit

Interface
REQ-001 The block SHALL have these parameters:
- WIDTH, 32, operand/result width in bits, a power of two from 8 to 64.
- SHW, $clog2(WIDTH), shift-amount width; derived, never overridden.

REQ-002 The block SHALL have these ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; accepted only when busy=0.
- func  in  6  operation code.
- inp1  in  WIDTH  operand A / dividend / shift source.
- inp2  in  WIDTH  operand B / divisor / variable shift amount (low SHW bits).
- shAmt  in  SHW  immediate shift amount.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse when results are valid.
- res1  out  WIDTH  primary result (low product / quotient).
- res2  out  WIDTH  secondary result (high product / remainder), otherwise 0.
- carryFlag, signFlag, overflowFlag, zeroFlag  out  1 each  status flags.

Function
REQ-003 Func codes SHALL be: 0 ADD, 1 SUB, 2 OR, 3 NEG (two's complement of inp1), 4 AND, 5 XOR, 6 SLL, 7 SRL, 8 SLLV, 9 SRLV, 10 SRA, 11 SRAV, 12 MULU, 13 DIVU; other codes are illegal.
REQ-004 Operands and func SHALL be captured on the edge where start=1 and busy=0; start while busy=1 SHALL be ignored with no side effect.
REQ-005 Codes 0-11 and illegal codes SHALL complete in one cycle: done=1 on the cycle after capture; busy stays 0.
REQ-006 MULU and DIVU SHALL be iterative, one bit per cycle: busy=1 from the cycle after capture for WIDTH cycles; done=1 and busy=0 on the cycle after the last iteration, i.e. done at WIDTH+1 cycles after capture.
REQ-007 start SHALL be accepted on the same cycle done=1 (back-to-back operation).
REQ-008 res1, res2 and the flags SHALL update only when done=1 and hold their values until the next done.
REQ-009 Immediate shifts SHALL use shAmt; variable shifts SHALL use inp2[SHW-1:0]; SRA/SRAV SHALL replicate inp1[WIDTH-1].
REQ-010 Flags for ADD/SUB/NEG SHALL be:
- carry = carry-out of the WIDTH-bit sum (SUB is computed as inp1+~inp2+1; NEG as ~inp1+1).
- overflow = signed overflow.
REQ-011 Flags for logic and shift ops SHALL be carry=0 and overflow=0.
REQ-012 For MULU: {res2,res1} SHALL equal the 2*WIDTH-bit unsigned product; overflow=1 iff res2!=0; carry=0.
REQ-013 For DIVU: res1=quotient, res2=remainder. For divisor 0: res1 SHALL be all ones, res2=inp1, overflow=1, and timing per REQ-006 is unchanged.
REQ-014 For all ops, sign=res1[WIDTH-1]; zero=1 iff res1==0 (for MULU, iff the full product is 0).
REQ-015 Illegal codes SHALL give res1=res2=0 and all flags 0 except zero=1.

Reset
REQ-016 rst=1 SHALL immediately force busy=0, done=0, res1=0, res2=0 and all flags 0, regardless of clock.
REQ-017 Reset during MULU/DIVU SHALL abort the operation with no done pulse; the first start after rst falls SHALL be accepted.

Structure
REQ-018 Package alu_seq_pkg SHALL hold the func-code constants and the default WIDTH.
REQ-019 The iterative multiply/divide datapath and its counter SHALL be sub-module alu_seq_muldiv (start, op, operands in; busy, done, hi/lo out). Single-cycle ops and flag logic SHALL stay in alu_seq_unit.

Verification (WIDTH=32)
REQ-020 ADD 0xFFFFFFFF+0xFFFFFFFF -> done after 1 cycle, res1=0xFFFFFFFE, carry=1, sign=1, overflow=0, zero=0; ADD 12+(-12) -> res1=0, carry=1, zero=1.
REQ-021 SRA inp1=0x80000000, shAmt=4 -> res1=0xF8000000; SRLV inp1=0xFFFFFFFF, inp2=5 -> res1=0x07FFFFFF.
REQ-022 MULU 0xFFFFFFFF*2 -> busy for 32 cycles, done at cycle 33, res1=0xFFFFFFFE, res2=1, overflow=1.
REQ-023 DIVU 100/7 -> res1=14, res2=2, overflow=0; DIVU 100/0 -> res1=0xFFFFFFFF, res2=100, overflow=1.
REQ-024 start with ADD 1+1 at cycle 5 of a MULU -> ignored, MULU result unchanged; a new start in the done cycle is accepted.
REQ-025 rst pulse at cycle 10 of a DIVU -> busy=0 immediately, no done pulse, all outputs 0; the next ADD 3+4 completes with res1=7.
